// File: rtl/fp_byte_frontend_pkg.sv
// Shared types and frame geometry for the byte-serial FP add/sub front end.
package fp_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        SEND = 2'd3
    } state_e;

    localparam int FRAME_OPERAND_BYTES = 8;
    localparam int RESULT_BYTES        = 4;
    localparam int CMD_SUB_BIT         = 0;

endpackage

// File: rtl/fp_byte_frontend_if.sv
// Byte-wide valid/ready ports of the FP front end: command frame in, result bytes out.
interface fp_byte_frontend_if;
    logic [7:0] in_byte;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    modport master (output in_byte, in_valid, out_ready,
                    input  in_ready, out_byte, out_valid);
    modport slave  (input  in_byte, in_valid, out_ready,
                    output in_ready, out_byte, out_valid);
endinterface

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// subnormal inputs and outputs supported, NaN results are the default quiet NaN.
module fp_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);
    logic        sign_a, sign_b, sign_l, sign_s;
    logic [7:0]  exp_a, exp_b, exp_l, exp_s, exp_diff, shamt;
    logic [23:0] man_a, man_b;
    logic [26:0] man_l, man_s, man_s_sh, man_s_al, man_n;
    logic        a_nan, b_nan, a_inf, b_inf, swap, sticky, round_up;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_r;
    logic [24:0] man_r;
    logic [22:0] frac_r;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // Subnormals use exponent 1 with a zero hidden bit.
    assign sign_a = a[31];
    assign sign_b = b[31] ^ sub;
    assign exp_a  = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
    assign exp_b  = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
    assign man_a  = {a[30:23] != 8'd0, a[22:0]};
    assign man_b  = {b[30:23] != 8'd0, b[22:0]};
    assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

    assign swap     = {exp_b, man_b} > {exp_a, man_a};
    assign sign_l   = swap ? sign_b : sign_a;
    assign sign_s   = swap ? sign_a : sign_b;
    assign exp_l    = swap ? exp_b : exp_a;
    assign exp_s    = swap ? exp_a : exp_b;
    assign man_l    = {(swap ? man_b : man_a), 3'b000};
    assign man_s    = {(swap ? man_a : man_b), 3'b000};
    assign exp_diff = exp_l - exp_s;

    always_comb begin
        man_s_sh = '0;
        sticky   = 1'b0;
        if (exp_diff >= 8'd27) begin
            sticky = |man_s;
        end else begin
            man_s_sh = man_s >> exp_diff;
            sticky   = |(man_s & ~({27{1'b1}} << exp_diff));
        end
    end

    assign man_s_al = {man_s_sh[26:1], man_s_sh[0] | sticky};
    assign sum = (sign_l ^ sign_s) ? ({1'b0, man_l} - {1'b0, man_s_al})
                                   : ({1'b0, man_l} + {1'b0, man_s_al});
    assign lz  = lzc27(sum[26:0]);

    // Left shift stops at exponent 1 so tiny results fall into the subnormal range.
    always_comb begin
        shamt = ({3'b000, lz} > (exp_l - 8'd1)) ? (exp_l - 8'd1) : {3'b000, lz};
        exp_n = {2'b00, exp_l};
        man_n = sum[26:0];
        if (sum[27]) begin
            man_n = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b00, exp_l} + 10'd1;
        end else if (lz != 5'd0) begin
            man_n = sum[26:0] << shamt;
            exp_n = {2'b00, exp_l} - {2'b00, shamt};
        end
    end

    always_comb begin
        round_up = man_n[2] & (man_n[1] | man_n[0] | man_n[3]);
        man_r    = {1'b0, man_n[26:3]} + {24'd0, round_up};
        exp_r    = 10'd0;
        frac_r   = man_r[22:0];
        if (man_r[24]) begin
            exp_r  = exp_n + 10'd1;
            frac_r = man_r[23:1];
        end else if (man_r[23]) begin
            exp_r  = exp_n;
        end
    end

    always_comb begin
        result = {sign_l, exp_r[7:0], frac_r};
        if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
            result = 32'h7FC0_0000;
        end else if (a_inf) begin
            result = {sign_a, 8'hFF, 23'd0};
        end else if (b_inf) begin
            result = {sign_b, 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            result = {sign_a & sign_b, 31'd0};
        end else if (exp_r >= 10'd255) begin
            result = {sign_l, 8'hFF, 23'd0};
        end
    end
endmodule

// File: rtl/fp_byte_frontend.sv
// Byte-serial front end: collects a 9-byte cmd/A/B frame, runs fp_addsub,
// and returns the 32-bit result as 4 bytes over valid/ready.
//
//  state | meaning
//  IDLE  | waiting for the command byte (sub select)
//  LOAD  | collecting 8 operand bytes, idle timeout armed
//  CALC  | one cycle, latch fp_addsub result
//  SEND  | streaming 4 result bytes, held under backpressure
module fp_byte_frontend
    import fp_frontend_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          MSB_FIRST      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    fp_byte_frontend_if.slave bus,
    output logic              busy,
    output logic              timeout
);
    localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [2:0] LAST_OPERAND = 3'(FRAME_OPERAND_BYTES - 1);
    localparam logic [1:0] LAST_RESULT  = 2'(RESULT_BYTES - 1);

    state_e            state_q, state_d;
    logic              sub_q, rdy_en_q;
    logic [31:0]       op_a_q, op_b_q, res_q, fp_result;
    logic [2:0]        byte_cnt_q;
    logic [1:0]        out_idx_q;
    logic [IDLE_W-1:0] idle_cnt_q;
    logic              in_ready_c, out_valid_c, in_xfer, out_xfer, idle_hit;
    logic [7:0]        out_byte_c;

    // Bit offset of byte lane idx within a 32-bit word, first-on-the-wire = idx 0.
    function automatic int unsigned byte_pos(input logic [1:0] idx);
        int unsigned lane;
        lane = MSB_FIRST ? 32'd3 - 32'(idx) : 32'(idx);
        return lane * 8;
    endfunction

    fp_addsub u_fp_addsub (
        .a      (op_a_q),
        .b      (op_b_q),
        .sub    (sub_q),
        .result (fp_result)
    );

    // rdy_en_q keeps in_ready low through reset and sets on the first clock after release.
    assign in_ready_c  = rdy_en_q && (state_q == IDLE || state_q == LOAD);
    assign out_valid_c = (state_q == SEND);
    assign in_xfer     = bus.in_valid && in_ready_c;
    assign out_xfer    = out_valid_c && bus.out_ready;
    assign idle_hit    = (TIMEOUT_CYCLES != 0) && (idle_cnt_q == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_xfer) state_d = LOAD;
            LOAD: begin
                if (in_xfer && byte_cnt_q == LAST_OPERAND) state_d = CALC;
                else if (!in_xfer && idle_hit)             state_d = IDLE;
            end
            CALC: state_d = SEND;
            SEND: if (out_xfer && out_idx_q == LAST_RESULT) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_byte_c = 8'h00;
        busy       = (state_q != IDLE);
        timeout    = (state_q == LOAD) && !in_xfer && idle_hit;
        if (state_q == SEND) out_byte_c = res_q[byte_pos(out_idx_q) +: 8];
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_byte  = out_byte_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q   <= 1'b0;
            sub_q      <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_q      <= '0;
            byte_cnt_q <= '0;
            out_idx_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    idle_cnt_q <= '0;
                    if (in_xfer) begin
                        sub_q      <= bus.in_byte[CMD_SUB_BIT];
                        byte_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (in_xfer) begin
                        if (!byte_cnt_q[2]) op_a_q[byte_pos(byte_cnt_q[1:0]) +: 8] <= bus.in_byte;
                        else                op_b_q[byte_pos(byte_cnt_q[1:0]) +: 8] <= bus.in_byte;
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        idle_cnt_q <= '0;
                    end else if (idle_hit) begin
                        op_a_q     <= '0;
                        op_b_q     <= '0;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                CALC: begin
                    res_q     <= fp_result;
                    out_idx_q <= '0;
                end
                SEND: if (out_xfer) out_idx_q <= out_idx_q + 2'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_byte_frontend.sv
// Directed bench for fp_byte_frontend: MSB-first and LSB-first instances share stimulus.
module tb_fp_byte_frontend;
    logic       clk, rst_n, use_lsb;
    logic [7:0] in_byte;
    logic       in_valid, out_ready;
    logic       busy_m, timeout_m, busy_l, timeout_l;
    logic       obs_in_ready, obs_out_valid, obs_busy, obs_timeout;
    logic [7:0] obs_out_byte;
    int         n_tests, n_fail;

    fp_byte_frontend_if bus_m ();
    fp_byte_frontend_if bus_l ();

    assign bus_m.in_byte   = in_byte;
    assign bus_m.in_valid  = in_valid && !use_lsb;
    assign bus_m.out_ready = out_ready;
    assign bus_l.in_byte   = in_byte;
    assign bus_l.in_valid  = in_valid && use_lsb;
    assign bus_l.out_ready = out_ready;

    fp_byte_frontend #(.TIMEOUT_CYCLES(255), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bus(bus_m), .busy(busy_m), .timeout(timeout_m));
    fp_byte_frontend #(.TIMEOUT_CYCLES(255), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .bus(bus_l), .busy(busy_l), .timeout(timeout_l));

    assign obs_in_ready  = use_lsb ? bus_l.in_ready  : bus_m.in_ready;
    assign obs_out_valid = use_lsb ? bus_l.out_valid : bus_m.out_valid;
    assign obs_out_byte  = use_lsb ? bus_l.out_byte  : bus_m.out_byte;
    assign obs_busy      = use_lsb ? busy_l    : busy_m;
    assign obs_timeout   = use_lsb ? timeout_l : timeout_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!obs_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_wait", obs_in_ready, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [71:0] f);
        for (int i = 0; i < 9; i++) send_byte(f[71 - 8*i -: 8]);
        in_valid = 1'b0;
    endtask

    task automatic recv_word(input string tag, input logic [31:0] exp_bytes);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int guard = 0;
            while (!obs_out_valid && guard < 40) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 40) chk({tag, "_valid_wait"}, obs_out_valid, 1);
            chk($sformatf("%s_byte%0d", tag, i), obs_out_byte, exp_bytes[31 - 8*i -: 8]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, first_idx;
        logic seen;
        n_tests = 0; n_fail = 0;
        rst_n = 1'b0; use_lsb = 1'b0;
        in_byte = 8'h00; in_valid = 1'b0; out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", obs_in_ready, 0);
        chk("rst_out_valid", obs_out_valid, 0);
        chk("rst_out_byte", obs_out_byte, 8'h00);
        chk("rst_busy", obs_busy, 0);
        chk("rst_timeout", obs_timeout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready", obs_in_ready, 1);

        // 1: 1.0 + 2.0 with latency check
        send_frame(72'h00_3F800000_40000000);
        chk("t1_calc_valid", obs_out_valid, 0);
        chk("t1_calc_busy", obs_busy, 1);
        chk("t1_calc_in_ready", obs_in_ready, 0);
        @(posedge clk); #1;
        chk("t1_lat_valid", obs_out_valid, 1);
        recv_word("t1", 32'h40400000);
        chk("t1_idle_busy", obs_busy, 0);

        // 2: 1.0 - 1.0 then 1.5 + 2.5 back to back
        send_frame(72'h01_3F800000_3F800000);
        recv_word("t2a", 32'h00000000);
        send_frame(72'h00_3FC00000_40200000);
        recv_word("t2b", 32'h40800000);

        // 3: backpressure in SEND, with a stray in_valid that must not be consumed
        out_ready = 1'b0;
        send_frame(72'h00_3F800000_40000000);
        @(posedge clk); #1;
        in_byte = 8'hAA; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_byte%0d", i), obs_out_byte, 8'h40);
            chk($sformatf("t3_hold_valid%0d", i), obs_out_valid, 1);
            chk($sformatf("t3_hold_in_ready%0d", i), obs_in_ready, 0);
        end
        in_valid = 1'b0;
        recv_word("t3", 32'h40400000);
        chk("t3_after_busy", obs_busy, 0);

        // 4: partial frame then 255 idle cycles
        out_ready = 1'b1;
        send_byte(8'h00); send_byte(8'h3F); send_byte(8'h80);
        in_valid = 1'b0;
        pulses = 0; first_idx = 0; seen = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (obs_timeout) begin
                pulses++;
                if (first_idx == 0) first_idx = i;
            end
            if (obs_out_valid) seen = 1'b1;
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_pulse_cycle", first_idx, 255);
        chk("t4_no_output", seen, 0);
        chk("t4_busy", obs_busy, 0);
        send_frame(72'h00_3F800000_40000000);
        recv_word("t4_next", 32'h40400000);

        // 5: async reset during the second result byte
        out_ready = 1'b0;
        send_frame(72'h00_3F800000_40000000);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("t5_second_byte", obs_out_byte, 8'h40);
        chk("t5_pre_valid", obs_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", obs_out_valid, 0);
        chk("t5_rst_busy", obs_busy, 0);
        chk("t5_rst_in_ready", obs_in_ready, 0);
        chk("t5_rst_byte", obs_out_byte, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_rel_in_ready", obs_in_ready, 1);
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (obs_out_valid) seen = 1'b1;
        end
        chk("t5_no_stale", seen, 0);
        send_frame(72'h00_3FC00000_40200000);
        recv_word("t5_next", 32'h40800000);

        // 6: LSB-first instance
        use_lsb = 1'b1;
        @(negedge clk);
        send_frame(72'h00_0000803F_00000040);
        recv_word("t6", 32'h00004040);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
